exp_cordic: RTL

Iterative hyperbolic CORDIC engine in rotation mode that computes e^z, cosh(z) and sinh(z) for a fixed-point argument. It is the inverse-direction counterpart of the log datapath: vectoring mode drives y to zero and accumulates atanh terms into z, while this block drives z to zero and rotates (x, y). One shared datapath iterates over successive cycles with a valid/ready handshake on each side. It uses the existing `atanh_lut` (6-bit index, 26-bit signed result).

---
 rtl/exp_cordic.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/exp_cordic.sv
// Iterative hyperbolic CORDIC, rotation mode: drives z to zero while rotating (x, y),
// giving cosh(z), sinh(z) and e^z = cosh + sinh from one shared shift-add datapath.
module exp_cordic #(
  parameter int                 ITER   = 24,
  parameter logic signed [26:0] X_INIT = 27'sd20258438,
  parameter logic signed [25:0] Z_MAX  = 26'sd4689232
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [25:0] z_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [26:0] exp_o,
  output logic signed [26:0] cosh_o,
  output logic signed [26:0] sinh_o,
  output logic               out_range
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // atanh(2^-i) in Q3.22, rounded to nearest; zero once the term drops below half an LSB
  function automatic logic signed [25:0] atanh_lut(input logic [5:0] idx);
    logic signed [25:0] v;
    case (idx)
      6'd1:    v = 26'sd2303957;
      6'd2:    v = 26'sd1071279;
      6'd3:    v = 26'sd527045;
      6'd4:    v = 26'sd262486;
      6'd5:    v = 26'sd131115;
      6'd6:    v = 26'sd65541;
      6'd7:    v = 26'sd32769;
      6'd8:    v = 26'sd16384;
      6'd9:    v = 26'sd8192;
      6'd10:   v = 26'sd4096;
      6'd11:   v = 26'sd2048;
      6'd12:   v = 26'sd1024;
      6'd13:   v = 26'sd512;
      6'd14:   v = 26'sd256;
      6'd15:   v = 26'sd128;
      6'd16:   v = 26'sd64;
      6'd17:   v = 26'sd32;
      6'd18:   v = 26'sd16;
      6'd19:   v = 26'sd8;
      6'd20:   v = 26'sd4;
      6'd21:   v = 26'sd2;
      6'd22:   v = 26'sd1;
      6'd23:   v = 26'sd1;
      default: v = 26'sd0;
    endcase
    return v;
  endfunction

  state_t             state_q, state_d;
  logic signed [26:0] x_q, x_d, y_q, y_d;
  logic signed [25:0] z_q, z_d;
  logic [5:0]         i_q, i_d;
  logic               rep_q, rep_d;
  logic signed [26:0] exp_q, exp_d, cosh_q, cosh_d, sinh_q, sinh_d;
  logic               range_q, range_d;

  logic signed [26:0] x_sh, y_sh, x_step, y_step;
  logic signed [25:0] z_step, atanh_v;
  logic               rep_pending;

  always_comb begin
    x_sh        = x_q >>> i_q;
    y_sh        = y_q >>> i_q;
    atanh_v     = atanh_lut(i_q);
    rep_pending = ((i_q == 6'd4) || (i_q == 6'd13)) && !rep_q;
    if (!z_q[25]) begin
      x_step = x_q + y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - atanh_v;
    end else begin
      x_step = x_q - y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + atanh_v;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    rep_d   = rep_q;
    exp_d   = exp_q;
    cosh_d  = cosh_q;
    sinh_d  = sinh_q;
    range_d = range_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = X_INIT;
          y_d     = '0;
          z_d     = z_i;
          i_d     = 6'd1;
          rep_d   = 1'b0;
          range_d = (z_i > Z_MAX) || (z_i < -Z_MAX);
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
        if (rep_pending) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          i_d   = i_q + 6'd1;
        end
        if ((i_q == 6'(ITER)) && !rep_pending) begin
          cosh_d  = x_step;
          sinh_d  = y_step;
          exp_d   = x_step + y_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      rep_q   <= 1'b0;
      exp_q   <= '0;
      cosh_q  <= '0;
      sinh_q  <= '0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      rep_q   <= rep_d;
      exp_q   <= exp_d;
      cosh_q  <= cosh_d;
      sinh_q  <= sinh_d;
      range_q <= range_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign exp_o     = exp_q;
  assign cosh_o    = cosh_q;
  assign sinh_o    = sinh_q;
  assign out_range = range_q;

endmodule
